// File: rtl/backprop_error_gen.sv
// Output-layer error source for learningNeuron: computes the saturated, shifted error target - neuron_out
// and accumulates per-epoch absolute loss. Optional deadband is enabled by defining BACKPROP_DEADBAND_EN.
module backprop_error_gen #(
  parameter int SETTLE_CYCLES     = 2,
  parameter int SAMPLES_PER_EPOCH = 4,
  parameter int ACC_W             = 40,
  parameter int DEADBAND          = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_start,
  input  logic [31:0]      target,
  input  logic [4:0]       rate_shift,
  input  logic [31:0]      neuron_out,
  output logic [31:0]      err_data,
  output logic             err_valid,
  input  logic             err_ready,
  output logic             busy,
  output logic [15:0]      sample_count,
  output logic [ACC_W-1:0] loss_out,
  output logic             epoch_done
);

  typedef enum logic [1:0] {IDLE, SETTLE, EMIT} state_t;

  localparam int                CNT_W       = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [15:0]       EPOCH_LEN   = 16'(SAMPLES_PER_EPOCH);
  localparam logic [ACC_W-1:0]  ACC_MAX     = '1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        target_q, target_d;
  logic [4:0]         shift_q, shift_d;
  logic [31:0]        err_data_q, err_data_d;
  logic               err_valid_q, err_valid_d;
  logic [15:0]        count_q, count_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   loss_q, loss_d;
  logic               epoch_done_q, epoch_done_d;

  logic [32:0]        diff;
  logic [31:0]        sat;
  logic [31:0]        abs_err;
  logic signed [31:0] shifted;
  logic [31:0]        err_calc;
  logic [ACC_W:0]     acc_sum;
  logic [ACC_W-1:0]   acc_sat;
  logic [15:0]        count_inc;

  // Datapath: 33-bit difference clamped to 32-bit signed, then learning-rate shift.
  always_comb begin
    diff = {target_q[31], target_q} - {neuron_out[31], neuron_out};
    if (diff[32] != diff[31]) begin
      sat = diff[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      sat = diff[31:0];
    end
    // |0x80000000| wraps to 0x80000000, which is the correct unsigned magnitude.
    abs_err  = sat[31] ? (~sat + 32'd1) : sat;
    shifted  = $signed(sat) >>> shift_q;
    err_calc = shifted;
`ifdef BACKPROP_DEADBAND_EN
    if (abs_err <= 32'(DEADBAND)) begin
      err_calc = 32'd0;
    end
`endif
    acc_sum   = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(abs_err);
    acc_sat   = acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];
    count_inc = count_q + 16'd1;
  end

`ifndef BACKPROP_DEADBAND_EN
  logic unused_deadband;
  assign unused_deadband = ^DEADBAND;
`endif

  // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    target_d     = target_q;
    shift_d      = shift_q;
    err_data_d   = err_data_q;
    err_valid_d  = err_valid_q;
    count_d      = count_q;
    acc_d        = acc_q;
    loss_d       = loss_q;
    epoch_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_start) begin
          target_d = target;
          shift_d  = rate_shift;
          cnt_d    = SETTLE_LOAD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          err_data_d  = err_calc;
          err_valid_d = 1'b1;
          acc_d       = acc_sat;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (err_ready) begin
          err_valid_d = 1'b0;
          state_d     = IDLE;
          if (count_inc == EPOCH_LEN) begin
            loss_d       = acc_q;
            acc_d        = '0;
            count_d      = '0;
            epoch_done_d = 1'b1;
          end else begin
            count_d = count_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments and an async reset so err_valid drops the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      target_q     <= '0;
      shift_q      <= '0;
      err_data_q   <= '0;
      err_valid_q  <= 1'b0;
      count_q      <= '0;
      acc_q        <= '0;
      loss_q       <= '0;
      epoch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      target_q     <= target_d;
      shift_q      <= shift_d;
      err_data_q   <= err_data_d;
      err_valid_q  <= err_valid_d;
      count_q      <= count_d;
      acc_q        <= acc_d;
      loss_q       <= loss_d;
      epoch_done_q <= epoch_done_d;
    end
  end

  assign err_data     = err_data_q;
  assign err_valid    = err_valid_q;
  assign busy         = (state_q != IDLE);
  assign sample_count = count_q;
  assign loss_out     = loss_q;
  assign epoch_done   = epoch_done_q;

endmodule

// File: tb/tb_backprop_error_gen.sv
// Self-checking bench for backprop_error_gen: table-driven samples plus hand-written
// timing, backpressure and mid-operation reset sequences.
module tb_backprop_error_gen;

  localparam int ACC_W = 40;
  localparam int LAT   = 4;  // negedges from start-drive until err_valid seen (SETTLE_CYCLES + 2)

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sample_start = 1'b0;
  logic [31:0]      target = '0;
  logic [4:0]       rate_shift = '0;
  logic [31:0]      neuron_out = '0;
  logic [31:0]      err_data;
  logic             err_valid;
  logic             err_ready = 1'b1;
  logic             busy;
  logic [15:0]      sample_count;
  logic [ACC_W-1:0] loss_out;
  logic             epoch_done;

  backprop_error_gen #(
    .SETTLE_CYCLES(2), .SAMPLES_PER_EPOCH(4), .ACC_W(ACC_W), .DEADBAND(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_start(sample_start), .target(target),
    .rate_shift(rate_shift), .neuron_out(neuron_out), .err_data(err_data),
    .err_valid(err_valid), .err_ready(err_ready), .busy(busy),
    .sample_count(sample_count), .loss_out(loss_out), .epoch_done(epoch_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] nout;
    logic [4:0]  sh;
    logic [31:0] exp_err;
    logic [31:0] exp_abs;
  } vec_t;

  vec_t vecs[9];

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [ACC_W-1:0] exp_acc = '0;
  logic [ACC_W-1:0] exp_loss = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] db(input logic [31:0] e, input logic [31:0] a);
`ifdef BACKPROP_DEADBAND_EN
    if (a <= 32'd2) return 32'd0;
`endif
    return e;
  endfunction

  task automatic start_and_wait(input logic [31:0] t, input logic [31:0] n, input logic [4:0] s);
    int lat;
    @(negedge clk);
    target = t; neuron_out = n; rate_shift = s; sample_start = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      sample_start = 1'b0;
      if (err_valid) break;
    end
    check("latency", 64'(lat), 64'(LAT));
  endtask

  // Called with err_ready=1 while err_valid is high; covers the handshake edge and epoch bookkeeping.
  task automatic finish_sample(input logic [31:0] abs_v);
    exp_acc = exp_acc + ACC_W'(abs_v);
    @(negedge clk);
    check("valid_after_hs", 64'(err_valid), 64'd0);
    check("busy_after_hs", 64'(busy), 64'd0);
    exp_count++;
    if (exp_count == 4) begin
      exp_loss = exp_acc; exp_acc = '0; exp_count = 0;
      check("epoch_done_pulse", 64'(epoch_done), 64'd1);
      check("loss_out", 64'(loss_out), 64'(exp_loss));
      @(negedge clk);
      check("epoch_done_drop", 64'(epoch_done), 64'd0);
    end else begin
      check("epoch_done_low", 64'(epoch_done), 64'd0);
      check("loss_held", 64'(loss_out), 64'(exp_loss));
    end
    check("sample_count", 64'(sample_count), 64'(exp_count));
  endtask

  task automatic do_vec(input vec_t v);
    start_and_wait(v.tgt, v.nout, v.sh);
    check("err_data", 64'(err_data), 64'(db(v.exp_err, v.exp_abs)));
    finish_sample(v.exp_abs);
  endtask

  initial begin
    vecs[0] = '{32'h4,        32'h10,       5'd2,  32'hFFFF_FFFD, 32'd12};
    vecs[1] = '{32'h7FFF_FFFF, 32'h8000_0000, 5'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vecs[2] = '{32'h8000_0000, 32'h7FFF_FFFF, 5'd0, 32'h8000_0000, 32'h8000_0000};
    vecs[3] = '{32'd5,        32'd4,        5'd0,  32'd1,         32'd1};
    vecs[4] = '{32'd0,        32'd2,        5'd0,  32'hFFFF_FFFE, 32'd2};
    vecs[5] = '{32'd3,        32'd0,        5'd0,  32'd3,         32'd3};
    vecs[6] = '{32'hFFFF_FFFF, 32'd3,       5'd1,  32'hFFFF_FFFE, 32'd4};
    vecs[7] = '{32'd9,        32'd1,        5'd3,  32'd1,         32'd8};
    vecs[8] = '{32'hFFFF_FF9C, 32'd0,       5'd31, 32'hFFFF_FFFF, 32'd100};

    #12;
    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_err_data", 64'(err_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_loss", 64'(loss_out), 64'd0);
    check("rst_count", 64'(sample_count), 64'd0);
    check("rst_epoch_done", 64'(epoch_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic positive error with cycle-exact timing.
    @(negedge clk);
    target = 32'h10; neuron_out = 32'h4; rate_shift = 5'd0; sample_start = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      sample_start = 1'b0;
      target = 32'h55;  // late change must not matter
      check("basic_busy", 64'(busy), 64'd1);
      check("basic_valid_low", 64'(err_valid), 64'd0);
    end
    @(negedge clk);
    check("basic_valid", 64'(err_valid), 64'd1);
    check("basic_data", 64'(err_data), 64'h0000_000C);
    check("basic_busy_emit", 64'(busy), 64'd1);
    finish_sample(32'd12);

    for (int i = 0; i < 3; i++) do_vec(vecs[i]);   // ends first epoch (includes saturation)
    for (int i = 3; i < 7; i++) do_vec(vecs[i]);   // |diff| 1,2,3,4 -> loss 10
    check("loss_ten", 64'(loss_out), 64'd10);
    do_vec(vecs[7]);
    do_vec(vecs[8]);

    // Backpressure with an ignored mid-wait start pulse.
    err_ready = 1'b0;
    start_and_wait(32'd20, 32'd5, 5'd0);
    check("bp_data", 64'(err_data), 64'd15);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sample_start = (i == 2);
      target = 32'h999;
      if (i == 4) err_ready = 1'b1;
      check("bp_valid_hold", 64'(err_valid), 64'd1);
      check("bp_data_hold", 64'(err_data), 64'd15);
    end
    sample_start = 1'b0;
    finish_sample(32'd15);
    @(negedge clk);
    check("bp_pulse_ignored", 64'(busy), 64'd0);

    // Reset during EMIT: err_valid must fall without a clock edge.
    err_ready = 1'b0;
    start_and_wait(32'd50, 32'd1, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(err_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_loss", 64'(loss_out), 64'd0);
    check("mid_rst_count", 64'(sample_count), 64'd0);
    exp_count = 0; exp_acc = '0; exp_loss = '0;
    @(negedge clk);
    rst_n = 1'b1;
    err_ready = 1'b1;
    do_vec(vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/backprop_error_gen.md
Name: backprop_error_gen

Overview:
- Output-layer error source for learningNeuron: drives the neuron's backpropStart input.
- Latches a training target on sample_start, waits a fixed settle time for the neuron's combinational output, then computes the scaled error target − out.
- Presents the error to the neuron's backprop side over a valid/ready handshake.
- Accumulates absolute error per epoch and reports it as a loss figure.

Parameters:
- SETTLE_CYCLES, 2: cycles waited after sample_start before neuron_out is sampled (0 allowed).
- SAMPLES_PER_EPOCH, 4: handshakes per epoch (≥1).
- ACC_W, 40: loss accumulator and loss_out width (≥33).
- DEADBAND, 0: deadband threshold; used only when BACKPROP_DEADBAND_EN is defined.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- sample_start, in, 1: start pulse; honoured only in IDLE.
- target, in, 32: signed expected output; latched with sample_start.
- rate_shift, in, 5: arithmetic right-shift amount (learning rate); latched with sample_start.
- neuron_out, in, 32: signed neuron output (the neuron's out).
- err_data, out, 32: signed error, goes to the neuron's backpropStart.
- err_valid, out, 1: err_data valid.
- err_ready, in, 1: consumer accepts err_data.
- busy, out, 1: high in any state other than IDLE.
- sample_count, out, 16: handshakes completed in the current epoch.
- loss_out, out, ACC_W: loss of the last completed epoch.
- epoch_done, out, 1: one-cycle pulse when loss_out updates.

Behaviour:
- Reset (async assert, sync release): state IDLE. Outputs err_data=0, err_valid=0, busy=0, sample_count=0, loss_out=0, epoch_done=0. Internal accumulator=0, latched target=0, latched rate_shift=0.
- FSM states: IDLE, SETTLE, EMIT.
- IDLE → SETTLE on the edge that samples sample_start=1:
  - Latch target and rate_shift.
  - Load the settle counter with SETTLE_CYCLES.
- SETTLE:
  - Counter ≠ 0: decrement.
  - Counter = 0: capture neuron_out, compute, register err_data, set err_valid=1, go to EMIT.
  - err_valid is first high after the (SETTLE_CYCLES+1)th edge following the start edge.
- Arithmetic:
  - diff = sign-extended 33-bit target − neuron_out.
  - Saturate to 32-bit signed: clamp to 0x7FFFFFFF / 0x80000000.
  - err_data = saturated diff >>> rate_shift (arithmetic, sign-filling).
- Loss:
  - At the capture edge, the accumulator adds |saturated diff| as a 32-bit unsigned value (|0x80000000| = 0x80000000).
  - The accumulator saturates at 2^ACC_W−1.
- EMIT:
  - err_valid and err_data are held stable while err_ready=0, with no timeout.
  - On the edge with err_valid & err_ready: err_valid→0, state→IDLE, sample_count+1.
  - The earliest new sample_start is accepted on the following edge.
- Epoch end: when the handshake makes sample_count reach SAMPLES_PER_EPOCH, on that same edge:
  - loss_out ← accumulator (including this sample).
  - Accumulator ← 0, sample_count ← 0.
  - epoch_done=1 for exactly the next cycle.
- Ignored inputs:
  - sample_start outside IDLE is ignored; it is not queued.
  - target and rate_shift changes after the start edge have no effect.
- Reset mid-operation: err_valid drops immediately (asynchronously). The in-progress sample and the partial epoch are discarded.

Optional Feature:
- Macro: BACKPROP_DEADBAND_EN.
- Defined: if |saturated diff| ≤ DEADBAND, err_data is forced to 0 and the handshake still occurs. Loss still accumulates the true |diff|.
- Undefined: the DEADBAND parameter is unused and err_data is always computed as above.

Test Plan:
- Basic error, positive: target=0x10, neuron_out=0x4, rate_shift=0, err_ready=1 → err_valid high after edge 3 from start for exactly 1 cycle, err_data=0x0000000C, busy high during edges 1–3.
- Basic error, negative with shift: target=0x4, neuron_out=0x10, rate_shift=2 → diff −12, err_data=0xFFFFFFFD (−3).
- Saturation:
  - target=0x7FFFFFFF, neuron_out=0x80000000 → err_data=0x7FFFFFFF.
  - Swapped operands → err_data=0x80000000; accumulator grows by 0x80000000.
- Backpressure: err_ready=0 for 5 cycles with sample_start pulsed mid-wait → err_valid and err_data constant, pulse ignored; err_ready=1 → one handshake, sample_count=1.
- Epoch:
  - Four samples with |diff| = 1, 2, 3, 4 → epoch_done one-cycle pulse, loss_out=10, sample_count=0.
  - Fifth sample starts a fresh accumulation.
- Reset mid-operation: rst_n low during EMIT → err_valid=0 without a clock edge; after release, state IDLE and loss_out=0.
- With BACKPROP_DEADBAND_EN, DEADBAND=2: diff=2 → err_data=0 and loss +2; diff=3 → err_data=3.
